// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory stage.
// Word/address width and depth match the attached data_memory.
package lsu_pkg;

  localparam int WORD_W = 19;
  localparam int DEPTH  = 512;
  localparam int TAG_W  = 4;

  // IDLE accepts requests; LD_WAIT covers the memory's read latency;
  // RESP holds the load result until writeback takes it.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    RESP    = 2'd2
  } lsu_state_t;

endpackage : lsu_pkg

// File: rtl/lsu_mem_stage.sv
// Load/store stage between execute and data_memory.
// Stores go straight to memory in the accept cycle and need no response.
// Loads block the stage until the result has been handed to writeback.
// Optional feature: define LSU_BOUNDS_CHECK_EN to suppress accesses with
// req_addr >= DEPTH; out-of-range loads then return zero data with resp_fault.
module lsu_mem_stage
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  // request from execute
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  // data_memory pins
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [WORD_W-1:0] mem_read_data,
  // response to writeback
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_data,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_fault
);

  lsu_state_t state_q;
  lsu_state_t state_d;

  logic accept;
  logic in_range;
  logic load_accept;
  logic load_fault;

`ifdef LSU_BOUNDS_CHECK_EN
  localparam logic [WORD_W-1:0] DepthLimit = WORD_W'(DEPTH);

  logic fault_q;

  // Address range check against the memory depth.
  always_comb begin
    in_range = (req_addr < DepthLimit);
  end

  // Remember whether the load in flight was out of range, so its data is
  // forced to zero and the fault flag travels with the response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (load_accept) begin
      fault_q <= ~in_range;
    end
  end

  assign load_fault = fault_q;
`else
  // Without the check every request is treated as in range.
  always_comb begin
    in_range = 1'b1;
  end

  assign load_fault = 1'b0;
`endif

  // Handshake and memory pin drive; strobes only fire for an accepted,
  // in-range request, and ready is held low during reset.
  always_comb begin
    req_ready      = rst_n & (state_q == IDLE);
    accept         = req_valid & req_ready;
    load_accept    = accept & ~req_is_store;
    mem_addr       = req_addr;
    mem_write_data = req_wdata;
    mem_write      = accept & req_is_store & in_range;
    mem_read       = load_accept & in_range;
  end

  // Next-state: stores leave the stage idle, loads walk through the read
  // latency cycle and then wait for writeback to take the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_accept) state_d = LD_WAIT;
      LD_WAIT: state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any load in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Response register: tag captured at accept, data captured at the end of
  // the latency cycle, then held untouched while waiting in RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_data <= '0;
      resp_tag  <= '0;
    end else begin
      if (load_accept) begin
        resp_tag <= req_tag;
      end
      if (state_q == LD_WAIT) begin
        resp_data <= load_fault ? '0 : mem_read_data;
      end
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_fault = load_fault;

endmodule : lsu_mem_stage
